// File: rtl/alu_funct_pkg.sv
// Function codes and FSM state type shared by the result select unit.
package alu_funct_pkg;

  localparam int unsigned funct_w = 6;

  localparam logic [funct_w-1:0] funct_sll  = 6'b000000;
  localparam logic [funct_w-1:0] funct_srl  = 6'b000010;
  localparam logic [funct_w-1:0] funct_mfhi = 6'b010000;
  localparam logic [funct_w-1:0] funct_mflo = 6'b010010;
  localparam logic [funct_w-1:0] funct_divu = 6'b011011;
  localparam logic [funct_w-1:0] funct_add  = 6'b100000;
  localparam logic [funct_w-1:0] funct_sub  = 6'b100010;
  localparam logic [funct_w-1:0] funct_and  = 6'b100100;
  localparam logic [funct_w-1:0] funct_or   = 6'b100101;
  localparam logic [funct_w-1:0] funct_slt  = 6'b101010;

  typedef enum logic {
    idle,
    wait_div
  } state_t;

endpackage

// File: rtl/result_select_unit_if.sv
// Request/result handshake bundle between the issue side and the result consumer.
interface result_select_unit_if
  import alu_funct_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);

  logic               in_valid;
  logic               in_ready;
  logic [funct_w-1:0] funct;
  logic [WIDTH-1:0]   alu_out;
  logic [WIDTH-1:0]   shift_out;
  logic [WIDTH-1:0]   hi_out;
  logic [WIDTH-1:0]   lo_out;
  logic               div_busy;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   data_out;
  logic               illegal;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output in_valid, funct, alu_out, shift_out, hi_out, lo_out, div_busy, out_ready,
    input  in_ready, out_valid, data_out, illegal, stall_cnt
  );

  modport slave (
    input  in_valid, funct, alu_out, shift_out, hi_out, lo_out, div_busy, out_ready,
    output in_ready, out_valid, data_out, illegal, stall_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over enable.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/result_select_unit.sv
// Picks the writeback source for a decoded funct and presents it as a
// registered valid/ready beat; MFHI/MFLO wait for the divider to finish.
module result_select_unit
  import alu_funct_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input logic                 clk,
  input logic                 reset,
  result_select_unit_if.slave bus
);

  state_t             state;
  state_t             state_nxt;
  logic [funct_w-1:0] funct_q;
  logic [funct_w-1:0] sel_funct;
  logic [WIDTH-1:0]   sel_data;
  logic               sel_illegal;
  logic               out_free;
  logic               in_ready_c;
  logic               accept;
  logic               is_mf;
  logic               load;
  logic               store_funct;
  logic               out_valid_q;
  logic [WIDTH-1:0]   data_q;
  logic               illegal_q;

  assign out_free   = !out_valid_q || bus.out_ready;
  assign in_ready_c = (state == idle) && out_free;
  assign accept     = bus.in_valid && in_ready_c;
  assign is_mf      = (bus.funct == funct_mfhi) || (bus.funct == funct_mflo);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= idle;
      funct_q <= '0;
    end else begin
      state <= state_nxt;
      if (store_funct) begin
        funct_q <= bus.funct;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      idle:     if (accept && is_mf && bus.div_busy) state_nxt = wait_div;
      wait_div: if (!bus.div_busy && out_free)       state_nxt = idle;
      default:  state_nxt = idle;
    endcase
  end

  // FSM outputs: when to capture a result and when to remember a deferred funct.
  always_comb begin
    load        = 1'b0;
    store_funct = 1'b0;
    sel_funct   = bus.funct;
    case (state)
      idle: begin
        store_funct = accept && is_mf && bus.div_busy;
        load        = accept && (bus.funct != funct_divu) && !(is_mf && bus.div_busy);
      end
      wait_div: begin
        sel_funct = funct_q;
        load      = !bus.div_busy && out_free;
      end
      default: ;
    endcase
  end

  // Source mux; unknown codes yield zero data flagged illegal.
  always_comb begin
    sel_data    = '0;
    sel_illegal = 1'b0;
    case (sel_funct)
      funct_and, funct_or, funct_add, funct_sub, funct_slt: sel_data = bus.alu_out;
      funct_sll, funct_srl:                                 sel_data = bus.shift_out;
      funct_mfhi:                                           sel_data = bus.hi_out;
      funct_mflo:                                           sel_data = bus.lo_out;
      default:                                              sel_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      illegal_q   <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      data_q      <= sel_data;
      illegal_q   <= sel_illegal;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (state == wait_div),
    .clr   (1'b0),
    .cnt   (bus.stall_cnt)
  );

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_result_select_unit.sv
// Directed checks of result_select_unit: source selection, backpressure,
// divider wait, stall counting and reset behaviour.
module tb_result_select_unit;
  import alu_funct_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  result_select_unit_if #(.WIDTH(32), .CNT_W(16)) bus ();

  result_select_unit #(
    .WIDTH (32),
    .CNT_W (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic v, input logic [31:0] d, input logic il);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'(v));
    check({tag, "_data"}, 64'(bus.data_out), 64'(d));
    check({tag, "_illegal"}, 64'(bus.illegal), 64'(il));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.funct     = '0;
    bus.alu_out   = '0;
    bus.shift_out = '0;
    bus.hi_out    = '0;
    bus.lo_out    = '0;
    bus.div_busy  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check_beat("reset", 1'b0, 32'h0, 1'b0);
    check("reset_stall", 64'(bus.stall_cnt), 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    tick();
    reset = 1'b0;

    // ADD: beat one cycle after the accept edge
    bus.in_valid = 1'b1;
    bus.funct    = funct_add;
    bus.alu_out  = 32'h0000_0007;
    tick();
    check_beat("add", 1'b1, 32'h7, 1'b0);

    // SRL with handshake on the same edge
    check("srl_in_ready", 64'(bus.in_ready), 64'd1);
    bus.funct     = funct_srl;
    bus.shift_out = 32'h8000_0000;
    tick();
    check_beat("srl", 1'b1, 32'h8000_0000, 1'b0);

    // DIVU accepted while SRL beat handshakes: no new beat
    bus.funct = funct_divu;
    tick();
    check("divu_valid", 64'(bus.out_valid), 64'd0);

    // AND/OR/SUB back-to-back
    bus.funct   = funct_and;
    bus.alu_out = 32'h0000_000a;
    tick();
    check_beat("and", 1'b1, 32'ha, 1'b0);
    bus.funct   = funct_or;
    bus.alu_out = 32'h0000_000b;
    tick();
    check_beat("or", 1'b1, 32'hb, 1'b0);
    bus.funct   = funct_sub;
    bus.alu_out = 32'h0000_000c;
    tick();
    check_beat("sub", 1'b1, 32'hc, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    check("b2b_drain", 64'(bus.out_valid), 64'd0);

    // Illegal code under backpressure
    bus.in_valid  = 1'b1;
    bus.funct     = 6'b111111;
    bus.alu_out   = 32'hffff_ffff;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    check_beat("ill", 1'b1, 32'h0, 1'b1);
    check("ill_in_ready", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_beat("ill_hold", 1'b1, 32'h0, 1'b1);
    end
    bus.out_ready = 1'b1;
    tick();
    check("ill_drain", 64'(bus.out_valid), 64'd0);

    // MFHI with divider idle
    bus.in_valid = 1'b1;
    bus.funct    = funct_mfhi;
    bus.hi_out   = 32'h0000_0055;
    tick();
    bus.in_valid = 1'b0;
    check_beat("mfhi", 1'b1, 32'h55, 1'b0);
    tick();
    check("mfhi_drain", 64'(bus.out_valid), 64'd0);

    // MFLO with divider busy for 5 cycles
    bus.in_valid = 1'b1;
    bus.funct    = funct_mflo;
    bus.div_busy = 1'b1;
    bus.lo_out   = 32'h0000_dead;
    tick();
    bus.in_valid = 1'b0;
    check("mflo_wait_in_ready", 64'(bus.in_ready), 64'd0);
    check("mflo_wait_valid", 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mflo_wait_in_ready", 64'(bus.in_ready), 64'd0);
      check("mflo_wait_valid", 64'(bus.out_valid), 64'd0);
      check("mflo_wait_stall", 64'(bus.stall_cnt), 64'(i + 1));
    end
    bus.div_busy = 1'b0;
    bus.lo_out   = 32'h1234_5678;
    check("mflo_release_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    check_beat("mflo", 1'b1, 32'h1234_5678, 1'b0);
    check("mflo_stall", 64'(bus.stall_cnt), 64'd5);
    check("mflo_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    check("mflo_drain", 64'(bus.out_valid), 64'd0);

    // Reset while waiting on the divider discards the pending MFHI
    bus.in_valid = 1'b1;
    bus.funct    = funct_mfhi;
    bus.div_busy = 1'b1;
    bus.hi_out   = 32'h0bad_0bad;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("rst_pre_stall", 64'(bus.stall_cnt), 64'd7);
    #2;
    reset = 1'b1;
    #1;
    check_beat("rst_mid", 1'b0, 32'h0, 1'b0);
    check("rst_mid_stall", 64'(bus.stall_cnt), 64'd0);
    check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
    #2;
    reset = 1'b0;
    bus.div_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_late_beat", 64'(bus.out_valid), 64'd0);
    end
    check("rst_stall_after", 64'(bus.stall_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/result_select_unit.md
RESULT_SELECT_UNIT -- requirements
Module: result_select_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of all result buses.
REQ-002 Parameter CNT_W, default 16, width of the stall counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  request accepted when in_valid && in_ready.
REQ-007 funct  input  6  function code.
REQ-008 alu_out, shift_out, hi_out, lo_out  input  WIDTH each  candidate result sources.
REQ-009 div_busy  input  1  divider is still writing Hi/Lo.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  consumer accepts beat when out_valid && out_ready.
REQ-012 data_out  output  WIDTH  selected result (registered).
REQ-013 illegal  output  1  beat carries an unsupported funct (registered, qualified by out_valid).
REQ-014 stall_cnt  output  CNT_W  count of cycles spent in WAIT_DIV.

Function
REQ-015 Codes: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010 SHALL select alu_out.
REQ-016 Codes: SLL 000000 and SRL 000010 SHALL select shift_out.
REQ-017 Codes: MFHI 010000 selects hi_out; MFLO 010010 selects lo_out.
REQ-018 DIVU 011011 SHALL be accepted and SHALL produce no output beat.
REQ-019 Any other code SHALL produce a beat with data_out = 0 and illegal = 1.
REQ-020 States: IDLE, WAIT_DIV; in_ready = (state == IDLE) && (!out_valid || out_ready).
REQ-021 IDLE, accepted non-MFHI/MFLO code: result registered on the accept edge, so out_valid = 1 in the next cycle (latency 1).
REQ-022 IDLE, accepted MFHI/MFLO with div_busy = 0: same as REQ-021, sampling hi_out/lo_out on the accept edge.
REQ-023 IDLE, accepted MFHI/MFLO with div_busy = 1:
  - store the funct;
  - go to WAIT_DIV.
REQ-024 WAIT_DIV: on the first edge where div_busy = 0 && (!out_valid || out_ready):
  - sample hi_out/lo_out per the stored funct;
  - set out_valid;
  - return to IDLE.
REQ-025 stall_cnt SHALL increment once per cycle spent in WAIT_DIV, saturating at all-ones.
REQ-026 While out_valid && !out_ready, data_out, illegal and out_valid SHALL hold stable.
REQ-027 out_valid SHALL clear after a handshake unless a new result is loaded on the same edge.
REQ-028 Simultaneous out handshake and new accept: the new result replaces the old with no bubble, giving one beat per cycle throughput.
REQ-029 Accepted DIVU with an output handshake on the same edge: out_valid SHALL fall to 0.

Reset
REQ-030 Reset asserted SHALL immediately force the following, asynchronously:
  - state = IDLE, stored funct = 0;
  - out_valid = 0, data_out = 0, illegal = 0;
  - stall_cnt = 0.
REQ-031 Reset during WAIT_DIV SHALL discard the pending MFHI/MFLO; no beat is produced for it.
REQ-032 First accept is possible on the first rising edge after reset deasserts.

Structure
REQ-033 Shared package alu_funct_pkg SHALL hold the 6-bit funct constants (incl. SRL, DIVU) and the state enum.
REQ-034 One sub-module is natural: sat_counter (parameter CNT_W; enable, clear; saturating), instantiated for stall_cnt.
REQ-035 Source selection SHALL be a single combinational case on funct feeding the output register; no latches.

Verification
REQ-036 ADD, alu_out = 0x0000_0007, out_ready = 1 -> next cycle out_valid = 1, data_out = 0x7, illegal = 0.
REQ-037 SRL, shift_out = 0x8000_0000 -> data_out = 0x8000_0000 one cycle later; DIVU -> no beat.
REQ-038 MFLO with div_busy = 1 held for 5 cycles, lo_out = 0x1234_5678 at release:
  - in_ready = 0 throughout;
  - beat data_out = 0x1234_5678;
  - stall_cnt = 5.
REQ-039 funct = 111111 -> beat with data_out = 0, illegal = 1; out_ready low for 3 cycles -> beat held unchanged, then one handshake.
REQ-040 Back-to-back AND/OR/SUB with out_ready = 1 -> three consecutive beats, no bubbles; reset asserted mid-WAIT_DIV -> out_valid = 0, stall_cnt = 0, no late beat.
